// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction fetch stage of the RISC-V core. Owns the program counter,
// presents it to the instruction cache, and latches the combinational cache
// read data into the fetch/decode pipeline register. Decode consumes that
// register through a valid/ready handshake. Execute can redirect the PC for
// branches and jumps.
//
// Build option:
//   FE_HALT_DETECT_EN  When defined, fetching HALT_WORD stops further
//                      fetching until a redirect or reset. When undefined,
//                      halted stays 0 and HALT_WORD is an ordinary
//                      instruction.
//
// Parameters:
//   RESET_PC        PC loaded on reset.
//   HALT_WORD       Encoding treated as halt (JAL x0, 0).
//
// Ports:
//   CLK             clock
//   RESET           synchronous, active-high reset
//   ic_pc           fetch address to the instruction cache (the PC register)
//   ic_instruction  cache read data for ic_pc, valid the same cycle
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     redirect target (low two bits ignored)
//   de_ready        decode accepts fd_* this cycle
//   fd_valid        fd_* holds an instruction for decode
//   fd_pc           PC of fd_instruction
//   fd_instruction  fetched instruction
//   fd_npc          fd_pc + 4
//   halted          fetch stopped on a halt word
//   fetch_count     number of instructions handed to decode (wraps)
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_WORD = 32'h0000_006F
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [63:0] ic_pc,
    input  logic [31:0] ic_instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        de_ready,
    output logic        fd_valid,
    output logic [63:0] fd_pc,
    output logic [31:0] fd_instruction,
    output logic [63:0] fd_npc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef FE_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [63:0] r_pc;
    logic        r_fd_valid;
    logic [63:0] r_fd_pc;
    logic [31:0] r_fd_instruction;
    logic [63:0] r_fd_npc;
    logic        r_halted;
    logic [31:0] r_fetch_count;

    // ------------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------------
    logic        w_transfer;
    logic        w_free;
    logic        w_advance;
    logic        w_halt_hit;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_redirect_target;
    logic        w_unused;

    assign w_transfer        = r_fd_valid && de_ready;
    assign w_free            = !r_fd_valid || de_ready;
    assign w_advance         = w_free && !redirect_valid && !r_halted;
    assign w_pc_plus4        = r_pc + 64'd4;      // modulo 2^64 by width
    assign w_redirect_target = {redirect_pc[63:2], 2'b00};

    // Only meaningful on an advance edge; folds to 0 when halt detection is
    // compiled out, which keeps r_halted permanently clear.
    assign w_halt_hit = HALT_EN && (ic_instruction == HALT_WORD);

    // Low PC bits are forced to zero, so the redirect target's low bits
    // are intentionally dropped.
    assign w_unused = ^redirect_pc[1:0];

    // ------------------------------------------------------------------------
    // Transfer counter: counts independently of redirect, so a redirect in the
    // same cycle as a transfer still credits that transfer.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fetch_count <= 32'd0;
        end else if (w_transfer) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // PC, pipeline register and halt flag.
    // Priority: reset > redirect > hold > advance > halted-idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc             <= RESET_PC;
            r_fd_valid       <= 1'b0;
            r_fd_pc          <= 64'd0;
            r_fd_instruction <= NOP_WORD;
            r_fd_npc         <= 64'd0;
            r_halted         <= 1'b0;
        end else if (redirect_valid) begin
            // Flushes the held instruction even while decode is stalling.
            r_pc       <= w_redirect_target;
            r_fd_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else if (!w_free) begin
            // Decode stalled on a valid instruction: everything holds.
            r_pc <= r_pc;
        end else if (w_advance) begin
            r_fd_pc          <= r_pc;
            r_fd_instruction <= ic_instruction;
            r_fd_npc         <= w_pc_plus4;
            r_fd_valid       <= 1'b1;
            r_pc             <= w_pc_plus4;
            r_halted         <= w_halt_hit;
        end else begin
            // Halted and the register is free: drain and wait for redirect.
            r_fd_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ic_pc          = r_pc;
    assign fd_valid       = r_fd_valid;
    assign fd_pc          = r_fd_pc;
    assign fd_instruction = r_fd_instruction;
    assign fd_npc         = r_fd_npc;
    assign halted         = r_halted;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage
// ----------------------------------------------------------------------------
// Self-checking bench for fetch_stage. A small instruction memory model
// answers the cache port. Expected deliveries are queued as stimulus is
// set up and checked whenever decode accepts an instruction. Directed
// checks cover reset, stall, redirect, PC wrap and halt behaviour.
// Expectations for halt behaviour follow FE_HALT_DETECT_EN.
// ============================================================================
module tb_fetch_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] npc;
    } fetch_t;

    logic        CLK;
    logic        RESET;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        de_ready;

    logic [63:0] ic_pc;
    logic [31:0] ic_instruction;
    logic        fd_valid;
    logic [63:0] fd_pc;
    logic [31:0] fd_instruction;
    logic [63:0] fd_npc;
    logic        halted;
    logic [31:0] fetch_count;

    // Second instance exercising the PC wrap from the top of the address space.
    logic        w_redirect_valid;
    logic [63:0] w_redirect_pc;
    logic        w_de_ready;
    logic [63:0] w_ic_pc;
    logic [31:0] w_ic_instruction;
    logic        w_fd_valid;
    logic [63:0] w_fd_pc;
    logic [31:0] w_fd_instruction;
    logic [63:0] w_fd_npc;
    logic        w_halted;
    logic [31:0] w_fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    fetch_t sb_q[$];

    // Instruction memory model
    function automatic logic [31:0] mem(input logic [63:0] pc);
        case (pc)
            64'h0:   mem = 32'h0050_0093;
            64'h4:   mem = 32'h00A0_0113;
            64'h8:   mem = 32'h0000_006F;
            default: mem = {pc[19:0], 12'h013};
        endcase
    endfunction

    assign ic_instruction   = mem(ic_pc);
    assign w_ic_instruction = mem(w_ic_pc);

    fetch_stage u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ic_pc          (ic_pc),
        .ic_instruction (ic_instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .de_ready       (de_ready),
        .fd_valid       (fd_valid),
        .fd_pc          (fd_pc),
        .fd_instruction (fd_instruction),
        .fd_npc         (fd_npc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .CLK            (CLK),
        .RESET          (RESET),
        .ic_pc          (w_ic_pc),
        .ic_instruction (w_ic_instruction),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .de_ready       (w_de_ready),
        .fd_valid       (w_fd_valid),
        .fd_pc          (w_fd_pc),
        .fd_instruction (w_fd_instruction),
        .fd_npc         (w_fd_npc),
        .halted         (w_halted),
        .fetch_count    (w_fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc);
        fetch_t e;
        e.pc    = pc;
        e.instr = mem(pc);
        e.npc   = pc + 64'd4;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: a transfer happens on the coming edge when fd_valid and
    // de_ready are both high; inputs are stable by the falling edge.
    always @(negedge CLK) begin
        if (mon_en && !RESET && fd_valid && de_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                fetch_t e;
                e = sb_q.pop_front();
                check("xfer_pc", fd_pc, e.pc);
                check("xfer_instr", 64'(fd_instruction), 64'(e.instr));
                check("xfer_npc", fd_npc, e.npc);
            end
        end
    end

`ifdef FE_HALT_DETECT_EN
    localparam bit  HALT_EN   = 1'b1;
    localparam int  CNT_BASE  = 3;
`else
    localparam bit  HALT_EN   = 1'b0;
    localparam int  CNT_BASE  = 4;
`endif

    initial begin
        RESET            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 64'd0;
        de_ready         = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 64'd0;
        w_de_ready       = 1'b1;

        // ---- reset state ----
        tick();
        tick();
        check("rst_fd_valid", 64'(fd_valid), 64'd0);
        check("rst_fd_pc", fd_pc, 64'd0);
        check("rst_fd_npc", fd_npc, 64'd0);
        check("rst_fd_instr", 64'(fd_instruction), 64'h13);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", 64'(fetch_count), 64'd0);
        check("rst_ic_pc", ic_pc, 64'd0);
        check("rst_wrap_ic_pc", w_ic_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // ---- first fetches, back to back ----
        mon_en = 1'b1;
        push_exp(64'h0);
        push_exp(64'h4);
        push_exp(64'h8);
        RESET    = 1'b0;
        de_ready = 1'b1;
        tick();
        check("c1_fd_valid", 64'(fd_valid), 64'd1);
        check("c1_fd_pc", fd_pc, 64'd0);
        check("c1_fd_instr", 64'(fd_instruction), 64'h0050_0093);
        check("c1_fd_npc", fd_npc, 64'd4);
        check("c1_count", 64'(fetch_count), 64'd0);
        check("wrap_c1_pc", w_fd_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_c1_npc", w_fd_npc, 64'd0);
        tick();
        check("c2_fd_pc", fd_pc, 64'd4);
        check("c2_fd_instr", 64'(fd_instruction), 64'h00A0_0113);
        check("c2_count", 64'(fetch_count), 64'd1);
        check("wrap_c2_pc", w_fd_pc, 64'd0);
        check("wrap_c2_valid", 64'(w_fd_valid), 64'd1);

        // ---- stall for three cycles ----
        de_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_fd_valid", 64'(fd_valid), 64'd1);
            check("stall_fd_pc", fd_pc, 64'd4);
            check("stall_ic_pc", ic_pc, 64'd8);
            check("stall_count", 64'(fetch_count), 64'd1);
        end

        // ---- resume; halt word at PC 8 ----
        de_ready = 1'b1;
        tick();                                   // edge A
        check("a_fd_pc", fd_pc, 64'd8);
        check("a_fd_instr", 64'(fd_instruction), 64'h6F);
        check("a_count", 64'(fetch_count), 64'd2);
        check("a_halted", 64'(halted), 64'(HALT_EN));
        if (!HALT_EN) push_exp(64'd12);
        tick();                                   // edge B
        check("b_count", 64'(fetch_count), 64'd3);
        check("b_halted", 64'(halted), 64'(HALT_EN));
        check("b_fd_valid", 64'(fd_valid), HALT_EN ? 64'd0 : 64'd1);
        check("b_ic_pc", ic_pc, HALT_EN ? 64'd12 : 64'd16);
        tick();                                   // edge C
        check("c_count", 64'(fetch_count), 64'(CNT_BASE));
        check("c_halted", 64'(halted), 64'(HALT_EN));
        check("c_fd_valid", 64'(fd_valid), HALT_EN ? 64'd0 : 64'd1);
        check("c_ic_pc", ic_pc, HALT_EN ? 64'd12 : 64'd20);

        // ---- redirect to 0 with decode stalled ----
        de_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd0;
        tick();                                   // edge D
        check("d_fd_valid", 64'(fd_valid), 64'd0);
        check("d_ic_pc", ic_pc, 64'd0);
        check("d_halted", 64'(halted), 64'd0);
        check("d_count", 64'(fetch_count), 64'(CNT_BASE));
        redirect_valid = 1'b0;
        tick();                                   // edge E
        check("e_fd_valid", 64'(fd_valid), 64'd1);
        check("e_fd_pc", fd_pc, 64'd0);
        tick();                                   // edge F (hold)
        check("f_fd_pc", fd_pc, 64'd0);
        check("f_ic_pc", ic_pc, 64'd4);

        // ---- redirect to misaligned target while stalled ----
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        tick();                                   // edge G
        check("g_fd_valid", 64'(fd_valid), 64'd0);
        check("g_ic_pc", ic_pc, 64'h100);
        redirect_valid = 1'b0;
        de_ready       = 1'b1;
        push_exp(64'h100);
        push_exp(64'h104);
        tick();                                   // edge H
        check("h_fd_valid", 64'(fd_valid), 64'd1);
        check("h_fd_pc", fd_pc, 64'h100);
        tick();                                   // edge I
        check("i_fd_pc", fd_pc, 64'h104);
        check("i_count", 64'(fetch_count), 64'(CNT_BASE + 1));

        // ---- redirect and transfer on the same edge ----
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        tick();                                   // edge J
        check("j_count", 64'(fetch_count), 64'(CNT_BASE + 2));
        check("j_fd_valid", 64'(fd_valid), 64'd0);
        check("j_ic_pc", ic_pc, 64'h200);
        redirect_valid = 1'b0;
        de_ready       = 1'b0;
        tick();                                   // edge K
        check("k_fd_pc", fd_pc, 64'h200);

        // ---- reset mid-stall and mid-redirect ----
        RESET          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        tick();                                   // edge L
        check("l_fd_valid", 64'(fd_valid), 64'd0);
        check("l_fd_pc", fd_pc, 64'd0);
        check("l_fd_instr", 64'(fd_instruction), 64'h13);
        check("l_ic_pc", ic_pc, 64'd0);
        check("l_count", 64'(fetch_count), 64'd0);
        check("l_halted", 64'(halted), 64'd0);

        mon_en = 1'b0;
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
